serial_adder: RTL and testbench

Bit-serial two-operand adder built around the team's single-bit full-adder cell. It latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, into the full-adder cell together with a registered carry. It collects the cell's sum bit into a shift register and feeds the cell's carry-out back as the next carry-in. It sits between the operand source and the result consumer, where area matters more than throughput.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the master supplies operands
// and a start request, the slave returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through a single
// full-adder cell with a registered carry; the result is published once per add.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Single-bit full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_shift_s;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       fa_s;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             last_bit_s;

    // Full-adder evaluation, accumulator shift preview and next-state decode.
    always_comb begin
        state_next_s             = state_r;
        fa_s                     = full_add(op_a_r[0], op_b_r[0], carry_r);
        acc_shift_s              = acc_r >> 1;
        acc_shift_s[WIDTH-1]     = fa_s[0];
        last_bit_s               = (cnt_r == CW'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, serial datapath and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_a_r  <= bus.a;
                        op_b_r  <= bus.b;
                        carry_r <= bus.cin;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                SHIFT: begin
                    acc_r   <= acc_shift_s;
                    carry_r <= fa_s[1];
                    op_a_r  <= op_a_r >> 1;
                    op_b_r  <= op_b_r >> 1;
                    cnt_r   <= cnt_r + CW'(1);
                    // The final bit lands in acc and sum on the same edge.
                    if (last_bit_s) begin
                        sum_r  <= acc_shift_s;
                        cout_r <= fa_s[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance, checked every cycle
// against a timing/arithmetic model plus directed literal expectations.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int compared   = 0;
    int mismatched = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 is the WIDTH=8 instance, index 1 the WIDTH=1 instance.
    // k counts edges since the accepting edge; the result appears at k == W.
    bit m_busy [2];
    bit m_done [2];
    int m_k    [2];
    int m_res  [2];
    int m_sum  [2];
    int m_cout [2];

    task automatic model_step(input int d, input int w, input bit st, input int a, input int b, input int c);
        if (!m_busy[d] && st) begin
            m_k[d]    = 0;
            m_res[d]  = a + b + c;
            m_busy[d] = 1'b1;
            m_done[d] = 1'b0;
        end else if (m_busy[d]) begin
            m_k[d]    = m_k[d] + 1;
            m_done[d] = (m_k[d] == w);
            if (m_k[d] == w) begin
                m_sum[d]  = m_res[d] % (1 << w);
                m_cout[d] = (m_res[d] >> w) & 1;
            end
            m_busy[d] = (m_k[d] <= w);
        end else begin
            m_done[d] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_done[d] = 1'b0; m_k[d] = 0;
                m_res[d]  = 0;    m_sum[d]  = 0;    m_cout[d] = 0;
            end
        end else begin
            model_step(0, 8, if8.start, int'(if8.a), int'(if8.b), int'(if8.cin));
            model_step(1, 1, if1.start, int'(if1.a), int'(if1.b), int'(if1.cin));
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("w8_busy", int'(if8.busy), int'(m_busy[0]));
        check("w8_done", int'(if8.done), int'(m_done[0]));
        check("w8_sum",  int'(if8.sum),  m_sum[0]);
        check("w8_cout", int'(if8.cout), m_cout[0]);
        check("w1_busy", int'(if1.busy), int'(m_busy[1]));
        check("w1_done", int'(if1.done), int'(m_done[1]));
        check("w1_sum",  int'(if1.sum),  m_sum[1]);
        check("w1_cout", int'(if1.cout), m_cout[1]);
    end

    task automatic wait_done8(output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (if8.done) seen = 1'b1;
        end
        if (!seen) check("w8_done_timeout", 0, 1);
    endtask

    task automatic wait_done1(output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (if1.done) seen = 1'b1;
        end
        if (!seen) check("w1_done_timeout", 0, 1);
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_cout, input string name);
        int lat;
        @(negedge clk); #1;
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
        wait_done8(lat);
        check({name, "_latency"}, lat, 8);
        check({name, "_sum"}, int'(if8.sum), int'(exp_sum));
        check({name, "_cout"}, int'(if8.cout), int'(exp_cout));
        @(posedge clk); #1;
    endtask

    task automatic do_op1(input logic a, input logic b, input logic c,
                          input logic exp_sum, input logic exp_cout, input string name);
        int lat;
        @(negedge clk); #1;
        if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
        @(posedge clk); #1;
        if1.start = 1'b0;
        wait_done1(lat);
        check({name, "_latency"}, lat, 1);
        check({name, "_sum"}, int'(if1.sum), int'(exp_sum));
        check({name, "_cout"}, int'(if1.cout), int'(exp_cout));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int off;
        rst_n     = 1'b0;
        if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = 1'b0;  if1.b = 1'b0;  if1.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(if8.busy), 0);
        check("reset_done", int'(if8.done), 0);
        check("reset_sum",  int'(if8.sum),  0);
        check("reset_cout", int'(if8.cout), 0);
        #1 rst_n = 1'b1;

        do_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
        do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple1");
        do_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple2");

        // start held high through SHIFT/DONE while operands change
        @(negedge clk); #1;
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.a = 8'h40; if8.b = 8'h03;
        wait_done8(lat);
        check("held_latency", lat, 8);
        check("held_sum", int'(if8.sum), 32'h02);
        wait_done8(lat);
        check("held_reaccept_latency", lat, 10);
        check("held_reaccept_sum", int'(if8.sum), 32'h43);
        if8.start = 1'b0;
        @(posedge clk); #1;

        // reset while bit 4 is in flight
        @(negedge clk); #1;
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(if8.busy), 0);
        check("abort_done", int'(if8.done), 0);
        check("abort_sum",  int'(if8.sum),  0);
        check("abort_cout", int'(if8.cout), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        do_op8(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, "after_reset");

        // back-to-back at the earliest legal edges
        do_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b_0");
        do_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "b2b_1");
        do_op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "b2b_2");

        // WIDTH=1 corner and a shuffled sweep of the full-adder truth table
        do_op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1_corner");
        off = int'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'((i + off) % 8);
            do_op1(v[2], v[1], v[0], v[2] ^ v[1] ^ v[0],
                   (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]), "w1_sweep");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
